// File: rtl/uart_tx_arbiter_if.sv
// Byte-source and uart_tx-side signals of the shared transmitter arbiter.
// master = sources plus uart_tx model, slave = the arbiter.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 2
);
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ack;
  logic [NUM_REQ-1:0]   grant;
  logic [7:0]           tx_data;
  logic                 tx_strobe;
  logic                 tx_ready;

  modport master (
    output req_data, req_valid, req_last, tx_ready,
    input  req_ack, grant, tx_data, tx_strobe
  );

  modport slave (
    input  req_data, req_valid, req_last, tx_ready,
    output req_ack, grant, tx_data, tx_strobe
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx between NUM_REQ byte sources, with a per-source
// packet lock so multi-byte messages are never interleaved.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int LOCK_TIMEOUT = 4096
) (
  input logic              mclk,
  input logic              reset,
  uart_tx_arbiter_if.slave bus
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TMR_W = (LOCK_TIMEOUT > 2) ? $clog2(LOCK_TIMEOUT) : 1;

  localparam logic [1:0] ST_ARB    = 2'd0;
  localparam logic [1:0] ST_SEND   = 2'd1;
  localparam logic [1:0] ST_SETTLE = 2'd2;
  localparam logic [1:0] ST_WAIT   = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic               lock_q, lock_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] req_ack_q, req_ack_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_strobe_q, tx_strobe_d;

  logic [IDX_W:0]     rr_pick;
  logic               sel_valid;
  logic [IDX_W-1:0]   sel_idx;
  logic [NUM_REQ-1:0] sel_onehot;

  // Returns {found, index}: first valid index at or after ptr, wrapping.
  function automatic logic [IDX_W:0] pick_first(input logic [NUM_REQ-1:0] valid,
                                                input logic [IDX_W-1:0]   ptr);
    logic [IDX_W:0] res;
    res = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      int j;
      j = (int'(ptr) + k) % NUM_REQ;
      if (valid[j]) res = {1'b1, IDX_W'(j)};
    end
    return res;
  endfunction

  always_comb begin
    rr_pick   = pick_first(bus.req_valid, ptr_q);
    sel_valid = lock_q ? bus.req_valid[owner_q] : rr_pick[IDX_W];
    sel_idx   = lock_q ? owner_q : rr_pick[IDX_W-1:0];
    for (int k = 0; k < NUM_REQ; k++) begin
      sel_onehot[k] = (sel_idx == IDX_W'(k));
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    lock_d      = lock_q;
    timer_d     = timer_q;
    grant_d     = grant_q;
    tx_data_d   = tx_data_q;
    req_ack_d   = '0;
    tx_strobe_d = 1'b0;
    unique case (state_q)
      ST_ARB: begin
        if (bus.tx_ready && sel_valid) begin
          // Byte is captured here so the SEND cycle presents registered data.
          state_d     = ST_SEND;
          tx_strobe_d = 1'b1;
          tx_data_d   = bus.req_data[8*sel_idx +: 8];
          req_ack_d   = sel_onehot;
          grant_d     = sel_onehot;
          owner_d     = sel_idx;
          lock_d      = !bus.req_last[sel_idx];
          timer_d     = '0;
          ptr_d       = (sel_idx == IDX_W'(NUM_REQ - 1)) ? '0 : sel_idx + 1'b1;
        end else if (lock_q && !bus.req_valid[owner_q]) begin
          if (timer_q == TMR_W'(LOCK_TIMEOUT - 1)) begin
            lock_d  = 1'b0;
            grant_d = '0;
            timer_d = '0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end
      ST_SEND:   state_d = ST_SETTLE;
      // uart_tx needs a cycle to drop ready after a strobe.
      ST_SETTLE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (bus.tx_ready) begin
          state_d = ST_ARB;
          if (!lock_q) grant_d = '0;
        end
      end
      default:   state_d = ST_ARB;
    endcase
  end

  always_ff @(posedge mclk) begin
    if (reset) begin
      state_q     <= ST_ARB;
      ptr_q       <= '0;
      owner_q     <= '0;
      lock_q      <= 1'b0;
      timer_q     <= '0;
      grant_q     <= '0;
      req_ack_q   <= '0;
      tx_data_q   <= '0;
      tx_strobe_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      lock_q      <= lock_d;
      timer_q     <= timer_d;
      grant_q     <= grant_d;
      req_ack_q   <= req_ack_d;
      tx_data_q   <= tx_data_d;
      tx_strobe_q <= tx_strobe_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.req_ack   = req_ack_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.tx_strobe = tx_strobe_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: two queued byte sources, a uart_tx ready model and a
// strobe monitor that checks each transmitted byte against the expected order.
module tb_uart_tx_arbiter;
  localparam int NUM_REQ      = 2;
  localparam int LOCK_TIMEOUT = 64;
  localparam int FRAME        = 6;

  typedef struct packed {
    logic [0:0] idx;
    logic [7:0] data;
  } exp_t;

  logic mclk;
  logic reset;
  logic hold_ready;
  int   busy;
  int   checks;
  int   errors;
  int   strobe_cnt;
  int   ack_cnt;

  exp_t       exp_q[$];
  logic [8:0] src0_q[$];
  logic [8:0] src1_q[$];

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .LOCK_TIMEOUT(LOCK_TIMEOUT)
  ) dut (
    .mclk (mclk),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    mclk = 1'b0;
    forever #5 mclk = ~mclk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic push_src(input int src, input logic last, input logic [7:0] data);
    if (src == 0) src0_q.push_back({last, data});
    else          src1_q.push_back({last, data});
  endtask

  task automatic push_exp(input int src, input logic [7:0] data);
    exp_t e;
    e.idx  = 1'(src);
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input string name, input int limit);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || src0_q.size() != 0 || src1_q.size() != 0 ||
            bus.req_valid != '0 || !bus.tx_ready) && n < limit) begin
      @(negedge mclk);
      n++;
    end
    check({name, "_drained"}, 32'(n < limit), 32'd1);
  endtask

  task automatic wait_strobe(input string name, input int limit);
    int n;
    int s;
    n = 0;
    s = strobe_cnt;
    while (strobe_cnt == s && n < limit) begin
      @(negedge mclk);
      n++;
    end
    check({name, "_strobe_seen"}, 32'(strobe_cnt != s), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge mclk);
    #1 reset = 1'b1;
    repeat (3) @(negedge mclk);
    #1 reset = 1'b0;
  endtask

  // Source driver: present the head of each queue, pop it once acked.
  initial begin
    bus.req_valid = '0;
    bus.req_last  = '0;
    bus.req_data  = '0;
    forever begin
      @(negedge mclk);
      if (bus.req_valid[0] && bus.req_ack[0]) begin
        void'(src0_q.pop_front());
        bus.req_valid[0] = 1'b0;
      end
      if (bus.req_valid[1] && bus.req_ack[1]) begin
        void'(src1_q.pop_front());
        bus.req_valid[1] = 1'b0;
      end
      if (!bus.req_valid[0] && src0_q.size() != 0) begin
        {bus.req_last[0], bus.req_data[7:0]} = src0_q[0];
        bus.req_valid[0] = 1'b1;
      end
      if (!bus.req_valid[1] && src1_q.size() != 0) begin
        {bus.req_last[1], bus.req_data[15:8]} = src1_q[0];
        bus.req_valid[1] = 1'b1;
      end
    end
  end

  // uart_tx model: busy for FRAME cycles after each strobe.
  initial begin
    busy         = 0;
    bus.tx_ready = 1'b1;
    forever begin
      @(negedge mclk);
      if (reset)              busy = 0;
      else if (bus.tx_strobe) busy = FRAME;
      else if (busy > 0)      busy--;
      bus.tx_ready = hold_ready && (busy == 0);
    end
  end

  // Monitor: every strobe must match the next scoreboard entry.
  initial begin
    exp_t e;
    strobe_cnt = 0;
    ack_cnt    = 0;
    forever begin
      @(negedge mclk);
      if (bus.req_ack != '0) ack_cnt++;
      if (!reset && bus.tx_strobe) begin
        strobe_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: got data 0x%0h, expected no strobe", bus.tx_data);
        end else begin
          e = exp_q.pop_front();
          check("tx_data", 32'(bus.tx_data), 32'(e.data));
          check("req_ack", 32'(bus.req_ack), 32'(2'b01 << e.idx));
          check("grant",   32'(bus.grant),   32'(2'b01 << e.idx));
        end
      end
    end
  end

  initial begin
    int  n;
    int  s;
    int  a;
    int  gap;
    logic [NUM_REQ-1:0] prev_grant;
    logic [NUM_REQ-1:0] mid_grant;

    checks     = 0;
    errors     = 0;
    reset      = 1'b1;
    hold_ready = 1'b1;
    repeat (4) @(negedge mclk);
    check("rst_tx_strobe", 32'(bus.tx_strobe), 32'd0);
    check("rst_tx_data",   32'(bus.tx_data),   32'd0);
    check("rst_req_ack",   32'(bus.req_ack),   32'd0);
    check("rst_grant",     32'(bus.grant),     32'd0);
    #1 reset = 1'b0;

    // 1: single byte, one-cycle latency, grant released after tx_ready.
    @(negedge mclk);
    #1;
    push_src(0, 1'b1, 8'h41);
    push_exp(0, 8'h41);
    @(negedge mclk);
    #1;
    check("t1_valid_up",     32'(bus.req_valid[0]), 32'd1);
    check("t1_no_strobe_yet", 32'(bus.tx_strobe),   32'd0);
    @(posedge mclk);
    #1;
    check("t1_strobe", 32'(bus.tx_strobe), 32'd1);
    check("t1_data",   32'(bus.tx_data),   32'h41);
    check("t1_grant",  32'(bus.grant),     32'h1);
    repeat (FRAME + 4) @(negedge mclk);
    check("t1_grant_released", 32'(bus.grant), 32'd0);
    wait_drain("t1", 50);

    // 2: both sources streaming single-byte messages alternate.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push_src(0, 1'b1, 8'h10 + 8'(i));
      push_src(1, 1'b1, 8'h20 + 8'(i));
      push_exp(0, 8'h10 + 8'(i));
      push_exp(1, 8'h20 + 8'(i));
    end
    wait_drain("t2", 300);

    // 3: locked three-byte message from source 1 is not interleaved.
    push_src(1, 1'b0, 8'hA0);
    push_src(1, 1'b0, 8'hA1);
    push_src(1, 1'b1, 8'hA2);
    push_exp(1, 8'hA0);
    wait_strobe("t3_a0", 50);
    push_src(0, 1'b1, 8'h30);
    push_src(0, 1'b1, 8'h31);
    push_exp(1, 8'hA1);
    push_exp(1, 8'hA2);
    push_exp(0, 8'h30);
    push_exp(0, 8'h31);
    wait_drain("t3", 300);

    // 4: source 1 abandons its message; lock times out, then source 0 goes.
    push_src(1, 1'b0, 8'hB0);
    push_exp(1, 8'hB0);
    wait_strobe("t4_b0", 50);
    push_src(0, 1'b1, 8'h55);
    push_exp(0, 8'h55);
    n          = 0;
    s          = strobe_cnt;
    prev_grant = bus.grant;
    mid_grant  = '0;
    while (strobe_cnt == s && n < LOCK_TIMEOUT + FRAME + 20) begin
      prev_grant = bus.grant;
      @(negedge mclk);
      n++;
      if (n == LOCK_TIMEOUT / 2) mid_grant = bus.grant;
    end
    gap = n;
    check("t4_strobe_seen",     32'(strobe_cnt != s),        32'd1);
    check("t4_lock_held_grant", 32'(mid_grant),              32'h2);
    check("t4_gap_min",         32'(gap >= LOCK_TIMEOUT),    32'd1);
    check("t4_grant_dropped",   32'(prev_grant),             32'd0);
    wait_drain("t4", 50);

    // 5: tx_ready low blocks everything, strobe follows ready by one cycle.
    @(negedge mclk);
    #1;
    hold_ready   = 1'b0;
    bus.tx_ready = 1'b0;
    push_src(0, 1'b1, 8'h77);
    push_exp(0, 8'h77);
    s = strobe_cnt;
    a = ack_cnt;
    repeat (100) @(negedge mclk);
    check("t5_no_strobe", 32'(strobe_cnt - s), 32'd0);
    check("t5_no_ack",    32'(ack_cnt - a),    32'd0);
    #1;
    hold_ready   = 1'b1;
    bus.tx_ready = 1'b1;
    @(posedge mclk);
    #1;
    check("t5_strobe_after_ready", 32'(bus.tx_strobe), 32'd1);
    wait_drain("t5", 50);

    // 6: reset during SEND clears outputs and the round-robin pointer.
    push_src(0, 1'b1, 8'h99);
    push_exp(0, 8'h99);
    n = 0;
    do begin
      @(negedge mclk);
      n++;
    end while (!bus.tx_strobe && n < 20);
    check("t6_send_reached", 32'(bus.tx_strobe), 32'd1);
    #1 reset = 1'b1;
    @(posedge mclk);
    #1;
    check("t6_rst_strobe", 32'(bus.tx_strobe), 32'd0);
    check("t6_rst_ack",    32'(bus.req_ack),   32'd0);
    check("t6_rst_grant",  32'(bus.grant),     32'd0);
    @(negedge mclk);
    #1 reset = 1'b0;
    push_src(1, 1'b1, 8'hC1);
    push_src(0, 1'b1, 8'hC0);
    push_exp(0, 8'hC0);
    push_exp(1, 8'hC1);
    wait_drain("t6", 100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
